// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-cycle data
// memory. Each granted request is latched, given exactly one memory access
// cycle, then answered with a one-cycle ack and registered read data.
// Ties between the ports are broken round-robin.
// Optional build macro DMEM_ARB_ADDR_CHECK_EN: reject unaligned or
// out-of-range (addr >= 1 KiB) requests with an ack+err pulse instead of
// touching memory.
module dmem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter bit INIT_PRIO_B = 1'b0
) (
    input  logic              clock,
    input  logic              rst,
    // port A (CPU load/store)
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    // port B (loader / debug / DMA)
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    // memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [DATA_W-1:0] mem_readData,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS_A = 2'd1,
        ACCESS_B = 2'd2
    } state_t;

    state_t            r_state;
    // 1 means port B wins the next tie (port A was granted last)
    logic              r_prio_b;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_a_ack;
    logic              r_b_ack;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic              w_eff_a;
    logic              w_eff_b;
    logic              w_grant_b;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // A port still holding req during its own ack cycle is not a new request
    assign w_eff_a     = a_req & ~r_a_ack;
    assign w_eff_b     = b_req & ~r_b_ack;
    assign w_grant_b   = w_eff_b & (~w_eff_a | r_prio_b);
    assign w_sel_we    = w_grant_b ? b_we    : a_we;
    assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;

`ifdef DMEM_ARB_ADDR_CHECK_EN
    logic r_a_err;
    logic r_b_err;
    logic w_bad;

    assign w_bad = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr[ADDR_W-1:10] != '0);
    assign a_err = r_a_err;
    assign b_err = r_b_err;
`else
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    // Strobes decode from state so reset removes them without waiting for a clock
    assign busy          = (r_state != IDLE);
    assign mem_memWrite  = busy &  r_we;
    assign mem_memRead   = busy & ~r_we;
    assign mem_addr      = r_addr;
    assign mem_writeData = r_wdata;
    assign a_ack         = r_a_ack;
    assign b_ack         = r_b_ack;
    assign a_rdata       = r_a_rdata;
    assign b_rdata       = r_b_rdata;

    // Arbitration FSM: grant in IDLE, one access cycle, then ack and return data
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_prio_b  <= INIT_PRIO_B;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
`ifdef DMEM_ARB_ADDR_CHECK_EN
            r_a_err   <= 1'b0;
            r_b_err   <= 1'b0;
`endif
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
`ifdef DMEM_ARB_ADDR_CHECK_EN
            r_a_err <= 1'b0;
            r_b_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_eff_a | w_eff_b) begin
`ifdef DMEM_ARB_ADDR_CHECK_EN
                        if (w_bad) begin
                            // rejected: answer next cycle without a memory cycle
                            if (w_grant_b) begin
                                r_b_ack <= 1'b1;
                                r_b_err <= 1'b1;
                            end else begin
                                r_a_ack <= 1'b1;
                                r_a_err <= 1'b1;
                            end
                            r_prio_b <= ~w_grant_b;
                        end else
`endif
                        begin
                            r_we    <= w_sel_we;
                            r_addr  <= w_sel_addr;
                            r_wdata <= w_sel_wdata;
                            r_state <= w_grant_b ? ACCESS_B : ACCESS_A;
                        end
                    end
                end
                ACCESS_A: begin
                    r_a_ack <= 1'b1;
                    if (!r_we) r_a_rdata <= mem_readData;
                    r_prio_b <= 1'b1;
                    r_state  <= IDLE;
                end
                ACCESS_B: begin
                    r_b_ack <= 1'b1;
                    if (!r_we) r_b_rdata <= mem_readData;
                    r_prio_b <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-cycle data memory. The memory has combinational read and a write on the rising clock edge, word-addressed by addr[9:2] (256 x 32 bits).
- Port A is the CPU datapath load/store path. Port B is a secondary master (program loader / debug / DMA).
- The block latches a request, runs exactly one memory access cycle for the granted port, then returns registered read data and an acknowledge pulse. Round-robin fairness applies when both ports request together.

Parameters:
- ADDR_W, 16, byte address width (matches memory addr).
- DATA_W, 32, data word width.
- INIT_PRIO_B, 0, initial value of the last-granted flag: 0 = port A wins the first tie, 1 = port B wins it.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held until a_ack.
- a_we  in  1  port A write enable (0 = read).
- a_addr  in  ADDR_W  port A byte address.
- a_wdata  in  DATA_W  port A write data.
- a_ack  out  1  one-cycle completion pulse.
- a_rdata  out  DATA_W  port A read data; valid when a_ack is high, held until the next port A read.
- a_err  out  1  access rejected (optional feature only).
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err: same as port A, for port B.
- mem_addr  out  ADDR_W  to memory addr.
- mem_writeData  out  DATA_W  to memory writeData.
- mem_memWrite  out  1  to memory memWrite.
- mem_memRead  out  1  to memory memRead.
- mem_readData  in  DATA_W  from memory readData.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst = 0, asynchronous): all outputs and registers are 0, state = IDLE, last_grant = INIT_PRIO_B. Because mem_memWrite and mem_memRead decode from state, they drop immediately. An access in flight is abandoned with no ack.
- States: IDLE, ACCESS_A, ACCESS_B.
- IDLE:
  - Effective request: eff_x = x_req AND NOT x_ack. This masks the request a port is still holding in its ack cycle.
  - Only eff_a: latch a_addr / a_wdata / a_we into the access registers, go to ACCESS_A.
  - Only eff_b: same for port B, go to ACCESS_B.
  - Both: grant the port not equal to last_grant.
  - Neither: stay in IDLE.
- ACCESS_x (exactly one cycle):
  - mem_addr and mem_writeData come from the latched registers.
  - mem_memWrite = latched we; mem_memRead = NOT latched we.
  - On the ending edge: memory performs any write; x_ack <= 1; on a read, x_rdata <= mem_readData; last_grant <= x; state <= IDLE.
- Latency: request seen in cycle N -> access in cycle N+1 -> ack and rdata in cycle N+2.
  - Minimum spacing between back-to-back accesses by the same port: 3 cycles.
  - Alternating ports: one access every 2 cycles.
- Write completion: x_rdata is unchanged; x_ack still pulses.
- Outside ACCESS states: mem_memWrite = mem_memRead = 0; mem_addr / mem_writeData hold their last latched values.
- Request inputs are ignored while in ACCESS states; a requester must hold its signals stable until it sees ack.
- x_ack is a single-cycle pulse; both acks are never high in the same cycle.
- x_err is 0 at all times when the optional feature is compiled out.

Optional Feature:
- Macro: DMEM_ARB_ADDR_CHECK_EN.
- Defined: in IDLE, a granted request with addr[1:0] != 0 or addr[ADDR_W-1:10] != 0 skips the ACCESS state.
  - Memory strobes stay 0 and state stays IDLE.
  - Next cycle: x_ack = 1 and x_err = 1 (one-cycle pulse); x_rdata is unchanged; last_grant updates to x.
- Undefined: no check; the address is passed through unchanged (memory uses addr[9:2]); x_err is tied to 0.

Test Plan:
- Reset, INIT_PRIO_B = 0: A write 0xDEADBEEF to 0x0010, then A read 0x0010 -> mem_memWrite high for exactly one cycle; read a_ack in cycle N+2 with a_rdata = 0xDEADBEEF.
- A and B both request reads of 0x0004 / 0x0008 in the same cycle, both held -> A served first, then B. Acks follow the A, B order, and keep alternating while both ports hold requests back to back.
- B holds b_req high continuously with 3 reads -> b_ack spaced 3 cycles apart; no duplicate access in the ack cycle.
- rst pulled low during ACCESS_A of a write -> mem_memWrite drops combinationally, a_ack never pulses, memory word unchanged, busy = 0.
- With DMEM_ARB_ADDR_CHECK_EN: B reads 0x0006 and then 0x0400 -> each returns b_ack = b_err = 1, no memory strobe, b_rdata unchanged. Without the macro: a read of 0x0400 returns word 0 and b_err = 0.
